// File: rtl/imem_loader.sv
// imem_loader: switch-loaded instruction RAM feeding the CPU, with debounced store
// button and LOAD/RUN mode control that holds the CPU while loading.
module imem_loader #(
  parameter int          DEPTH           = 256,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [7:0]  FILL            = 8'h00
) (
  input  logic       Clk_O,
  input  logic       Reset,
  input  logic       Mode,
  input  logic [7:0] Sw,
  input  logic       Store,
  input  logic [7:0] PC,
  output logic [7:0] Instruction,
  output logic [7:0] Load_Addr,
  output logic [8:0] Count,
  output logic       Full,
  output logic       Cpu_Hold
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic mode_m_q, mode_s_q, store_m_q, store_s_q;
  logic store_stable_q, store_stable_d, store_pulse_q, store_pulse_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [7:0] load_addr_q, load_addr_d, instr_q, instr_d;
  logic [8:0] count_q, count_d;
  logic differ, db_done, full, we, leave_run;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [7:0] mem [DEPTH];

  assign wr_idx = load_addr_q[AW-1:0];
  assign rd_idx = PC[AW-1:0];

  always_comb begin
    state_d        = mode_s_q ? RUN : LOAD;
    differ         = store_s_q != store_stable_q;
    db_done        = differ && db_cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    db_cnt_d       = (differ && !db_done) ? db_cnt_q + 1'b1 : '0;
    store_stable_d = db_done ? store_s_q : store_stable_q;
    store_pulse_d  = db_done && store_s_q;
    full           = count_q == 9'(DEPTH);
    leave_run      = state_q == RUN && !mode_s_q;
    // A press landing on the LOAD->RUN edge is dropped: the write needs LOAD that stays LOAD.
    we             = store_pulse_q && !full && state_q == LOAD && !mode_s_q;
    load_addr_d    = leave_run ? 8'd0 :
                     we ? (load_addr_q == 8'(DEPTH - 1) ? 8'd0 : load_addr_q + 8'd1) : load_addr_q;
    count_d        = leave_run ? 9'd0 : we ? count_q + 9'd1 : count_q;
    instr_d        = (state_q == RUN && {1'b0, PC} < count_q && {1'b0, PC} < 9'(DEPTH)) ? mem[rd_idx] : FILL;
  end

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      state_q        <= LOAD;
      mode_m_q       <= 1'b0;
      mode_s_q       <= 1'b0;
      store_m_q      <= 1'b0;
      store_s_q      <= 1'b0;
      store_stable_q <= 1'b0;
      store_pulse_q  <= 1'b0;
      db_cnt_q       <= '0;
      load_addr_q    <= 8'd0;
      count_q        <= 9'd0;
      instr_q        <= FILL;
    end else begin
      state_q        <= state_d;
      mode_m_q       <= Mode;
      mode_s_q       <= mode_m_q;
      store_m_q      <= Store;
      store_s_q      <= store_m_q;
      store_stable_q <= store_stable_d;
      store_pulse_q  <= store_pulse_d;
      db_cnt_q       <= db_cnt_d;
      load_addr_q    <= load_addr_d;
      count_q        <= count_d;
      instr_q        <= instr_d;
    end
  end

  always_ff @(posedge Clk_O) begin
    if (we) mem[wr_idx] <= Sw;
  end

  assign Instruction = instr_q;
  assign Load_Addr   = load_addr_q;
  assign Count       = count_q;
  assign Full        = full;
  assign Cpu_Hold    = state_q != RUN;
endmodule
